// File: rtl/ov5640_pixel_capture_if.sv
// rtl/ov5640_pixel_capture_if.sv - assembled pixel stream from DVP capture to the YCbCr stage
//
// Signals:
//   pre_wr_en    one-cycle strobe per assembled pixel
//   ov5640_data  RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//   pre_href     line valid, aligned with the pixel strobes
//   pre_vsync    frame sync, aligned with the pixel strobes
// Modports: master = capture block (driver), slave = downstream consumer.

interface ov5640_pixel_capture_if;
  logic        pre_wr_en;
  logic [15:0] ov5640_data;
  logic        pre_href;
  logic        pre_vsync;

  modport master (
    output pre_wr_en,
    output ov5640_data,
    output pre_href,
    output pre_vsync
  );

  modport slave (
    input pre_wr_en,
    input ov5640_data,
    input pre_href,
    input pre_vsync
  );
endinterface

// File: rtl/ov5640_pixel_capture.sv
// rtl/ov5640_pixel_capture.sv - OV5640 DVP byte-pair to RGB565 pixel capture with frame skip and geometry check
//
// Ports:
//   sys_clk      camera PCLK, rising-edge logic
//   sys_rst_n    asynchronous active-low reset
//   cfg_done     sensor configuration complete (level)
//   cam_vsync    camera frame sync, active high
//   cam_href     camera line valid, active high
//   cam_data     camera byte bus, high byte first
//   pix          pixel stream (master): pre_wr_en, ov5640_data, pre_href, pre_vsync
//   frame_valid  frames are being forwarded (skip count done)
//   frame_err    geometry check result for the last fully forwarded frame

module ov5640_pixel_capture #(
  parameter int FRAME_SKIP = 10,
  parameter int H_PIXEL    = 640,
  parameter int V_PIXEL    = 480
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          cfg_done,
  input  logic                          cam_vsync,
  input  logic                          cam_href,
  input  logic [7:0]                    cam_data,
  ov5640_pixel_capture_if.master        pix,
  output logic                          frame_valid,
  output logic                          frame_err
);

  localparam int FCW = ($clog2(FRAME_SKIP + 1) > 4) ? $clog2(FRAME_SKIP + 1) : 4;

  logic           vsync_d1, vsync_d2;
  logic           href_d1, href_d2;
  logic [7:0]     data_d1;
  logic [7:0]     high_byte;
  logic           phase;
  logic           in_line;
  logic [FCW-1:0] frame_cnt;
  logic [11:0]    pix_cnt;
  logic [11:0]    line_cnt;
  logic           line_err_acc;

  logic           vs_rise, hs_rise, hs_fall;
  logic           pix_done, fwd, line_end, line_bad;
  logic [11:0]    pix_cnt_nxt;
  logic [11:0]    line_cnt_nxt;
  logic           err_acc_nxt;

  always_comb begin
    vs_rise  = vsync_d1 & ~vsync_d2;
    hs_rise  = href_d1 & ~href_d2;
    hs_fall  = ~href_d1 & href_d2;
    pix_done = href_d1 & phase;
    // cfg_done gates directly so forwarding stops on the very next edge
    fwd      = frame_valid & cfg_done;
    // A vsync rise during an active line closes that line first
    line_end = in_line & (hs_fall | (vs_rise & href_d1));

    pix_cnt_nxt = pix_cnt;
    if (hs_rise)
      pix_cnt_nxt = 12'd0;
    else if (pix_done && pix_cnt != 12'hFFF)
      pix_cnt_nxt = pix_cnt + 12'd1;

    // Half pixel pending only once href has dropped with phase still set
    line_bad     = (pix_cnt_nxt != 12'(H_PIXEL)) | (phase & ~href_d1);
    line_cnt_nxt = line_cnt + {11'd0, line_end};
    err_acc_nxt  = line_err_acc | (line_end & line_bad);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_d1        <= 1'b0;
      vsync_d2        <= 1'b0;
      href_d1         <= 1'b0;
      href_d2         <= 1'b0;
      data_d1         <= 8'd0;
      high_byte       <= 8'd0;
      phase           <= 1'b0;
      in_line         <= 1'b0;
      frame_cnt       <= '0;
      pix_cnt         <= 12'd0;
      line_cnt        <= 12'd0;
      line_err_acc    <= 1'b0;
      frame_valid     <= 1'b0;
      frame_err       <= 1'b0;
      pix.pre_wr_en   <= 1'b0;
      pix.ov5640_data <= 16'd0;
      pix.pre_href    <= 1'b0;
      pix.pre_vsync   <= 1'b0;
    end else begin
      vsync_d1 <= cam_vsync;
      vsync_d2 <= vsync_d1;
      href_d1  <= cam_href;
      href_d2  <= href_d1;
      data_d1  <= cam_data;

      // Byte assembly
      phase <= href_d1 ? ~phase : 1'b0;
      if (href_d1 && !phase)
        high_byte <= data_d1;
      if (pix_done)
        pix.ov5640_data <= {high_byte, data_d1};
      pix.pre_wr_en <= pix_done & fwd;
      pix.pre_href  <= href_d1 & fwd;
      pix.pre_vsync <= vsync_d1 & fwd;

      // Geometry accounting
      pix_cnt <= pix_cnt_nxt;
      if (hs_rise)
        in_line <= 1'b1;
      else if (line_end)
        in_line <= 1'b0;

      if (vs_rise) begin
        line_cnt     <= 12'd0;
        line_err_acc <= 1'b0;
        if (frame_valid)
          frame_err <= (line_cnt_nxt != 12'(V_PIXEL)) | err_acc_nxt;
      end else begin
        line_cnt     <= line_cnt_nxt;
        line_err_acc <= err_acc_nxt;
      end

      // Frame skip
      if (!cfg_done) begin
        frame_cnt   <= '0;
        frame_valid <= 1'b0;
      end else if (vs_rise) begin
        if (frame_cnt < FCW'(FRAME_SKIP))
          frame_cnt <= frame_cnt + 1'b1;
        else
          frame_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ov5640_pixel_capture.sv
// tb/tb_ov5640_pixel_capture.sv - scoreboard bench for ov5640_pixel_capture

module tb_ov5640_pixel_capture;

  localparam int FS = 2;
  localparam int HP = 4;
  localparam int VP = 3;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       cfg_done;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_data;
  logic       frame_valid;
  logic       frame_err;

  ov5640_pixel_capture_if pix_if ();

  ov5640_pixel_capture #(
    .FRAME_SKIP (FS),
    .H_PIXEL    (HP),
    .V_PIXEL    (VP)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .cfg_done    (cfg_done),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .pix         (pix_if),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   pulses      = 0;

  // Frame-level reference state
  int   exp_cnt     = 0;
  bit   exp_valid   = 0;
  bit   exp_err     = 0;
  bit   prev_bad    = 0;

  always @(posedge sys_clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected pixels on each strobe, checks data, arrival cycle,
  // and that pre_href led the first strobe of a line by exactly one cycle.
  bit href_q     = 0;
  bit first_pend = 0;
  int rise_cyc   = 0;
  always @(negedge sys_clk) begin
    exp_t e;
    if (pix_if.pre_href && !href_q) begin
      rise_cyc   = cyc;
      first_pend = 1;
    end
    if (pix_if.pre_wr_en) begin
      pulses++;
      if (first_pend) begin
        chk("href_lead", 32'(cyc - rise_cyc), 32'd1);
        first_pend = 0;
      end
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pixel: got %04h, expected no strobe (cycle %0d)",
                 pix_if.ov5640_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("pixel_data", 32'(pix_if.ov5640_data), 32'(e.d));
        chk("pixel_cycle", 32'(cyc), 32'(e.c));
      end
    end
    href_q = pix_if.pre_href;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input int fr, input int ln, input int k);
    int v;
    if (fr == 3 && ln == 0 && k < 4) begin
      case (k)
        0:       return 8'hF8;
        1:       return 8'h1F;
        2:       return 8'h07;
        default: return 8'hE0;
      endcase
    end
    v = fr * 37 + ln * 11 + k * 5 + 1;
    return v[7:0];
  endfunction

  task automatic frame_start();
    bit valid_before;
    valid_before = exp_valid;
    if (cfg_done) begin
      if (exp_cnt < FS) exp_cnt++;
      else              exp_valid = 1;
    end
    if (valid_before) exp_err = prev_bad;
    cam_vsync = 1'b1;
    repeat (4) tick();
    chk("frame_valid", 32'(frame_valid), 32'(exp_valid));
    chk("frame_err", 32'(frame_err), 32'(exp_err));
    chk("pre_vsync", 32'(pix_if.pre_vsync), 32'(exp_valid));
    cam_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_line(input int fr, input int ln, input int nbytes, input int drop_at);
    logic [7:0] b;
    logic [7:0] hi;
    exp_t       e;
    hi = 8'd0;
    for (int k = 0; k < nbytes; k++) begin
      b        = byte_of(fr, ln, k);
      cam_href = 1'b1;
      cam_data = b;
      if (k % 2 == 0) begin
        hi = b;
      end else if (exp_valid && (drop_at < 0 || k <= drop_at - 2)) begin
        e.d = {hi, b};
        e.c = cyc + 2;
        sb.push_back(e);
      end
      if (k == drop_at) begin
        cfg_done  = 1'b0;
        exp_valid = 0;
        exp_cnt   = 0;
      end
      tick();
      if (k == drop_at) begin
        chk("drop_frame_valid", 32'(frame_valid), 32'd0);
        chk("drop_pre_wr_en", 32'(pix_if.pre_wr_en), 32'd0);
        chk("drop_pre_href", 32'(pix_if.pre_href), 32'd0);
        chk("drop_pre_vsync", 32'(pix_if.pre_vsync), 32'd0);
      end
    end
    cam_href = 1'b0;
    cam_data = 8'd0;
    repeat (4) tick();
  endtask

  task automatic send_frame(input int fr, input int nlines, input int odd_ln, input int drop_ln);
    bit bad;
    int nb;
    frame_start();
    bad = (nlines != VP);
    for (int ln = 0; ln < nlines; ln++) begin
      nb = (ln == odd_ln) ? 2 * HP + 1 : 2 * HP;
      if (nb != 2 * HP) bad = 1;
      send_line(fr, ln, nb, (ln == drop_ln) ? 6 : -1);
    end
    prev_bad = bad;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pre_wr_en"}, 32'(pix_if.pre_wr_en), 32'd0);
    chk({tag, "_ov5640_data"}, 32'(pix_if.ov5640_data), 32'd0);
    chk({tag, "_pre_href"}, 32'(pix_if.pre_href), 32'd0);
    chk({tag, "_pre_vsync"}, 32'(pix_if.pre_vsync), 32'd0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    exp_t e;
    sys_rst_n = 1'b0;
    cfg_done  = 1'b0;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = 8'd0;
    repeat (2) tick();
    chk_reset_outputs("reset");
    sys_rst_n = 1'b1;
    cfg_done  = 1'b1;
    tick();

    // Skip two frames, forward frames 3 and 4 (frame 3 starts with F81F, 07E0)
    for (int fr = 1; fr <= 4; fr++) send_frame(fr, VP, -1, -1);
    chk("pulses_frames_3_4", 32'(pulses), 32'd24);

    // Odd byte count, then clean frames
    send_frame(5, VP, 0, -1);
    send_frame(6, VP, -1, -1);
    send_frame(7, VP, -1, -1);

    // Short frame (2 lines), then clean
    send_frame(8, 2, -1, -1);
    send_frame(9, VP, -1, -1);

    // cfg_done drop mid-line, then reassert and re-skip
    send_frame(10, VP, -1, 1);
    cfg_done = 1'b1;
    repeat (3) tick();
    for (int fr = 11; fr <= 13; fr++) send_frame(fr, VP, -1, -1);

    // Asynchronous reset between edges with a half pixel pending
    frame_start();
    cam_href = 1'b1;
    cam_data = 8'hA5;
    tick();
    cam_data = 8'h3C;
    e.d = 16'hA53C;
    e.c = cyc + 2;
    sb.push_back(e);
    tick();
    cam_data = 8'h77;
    tick();
    @(negedge sys_clk);
    #2;
    chk("pre_href_before_rst", 32'(pix_if.pre_href), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    chk("sb_empty_at_rst", 32'(sb.size()), 32'd0);
    cam_href = 1'b0;
    cam_data = 8'd0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    exp_cnt   = 0;
    exp_valid = 0;
    exp_err   = 0;
    prev_bad  = 0;
    repeat (2) tick();

    for (int fr = 15; fr <= 17; fr++) send_frame(fr, VP, -1, -1);
    frame_start();
    repeat (5) tick();
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ov5640_pixel_capture.md
Name: ov5640_pixel_capture

Overview:
- Camera-side front end that takes the OV5640 8-bit DVP bus (two bytes per RGB565 pixel) and assembles 16-bit pixels.
- Produces the write-enable, pixel word, href and vsync consumed by the downstream RGB565-to-YCbCr stage.
- Discards the first FRAME_SKIP frames after sensor configuration, so only stable frames reach the ISP.
- Checks every valid frame's geometry and flags malformed frames.

Parameters:
FRAME_SKIP, 10, number of complete frames ignored after cfg_done rises (settling time for sensor registers/AEC).
H_PIXEL, 640, expected pixels per line, used for geometry check.
V_PIXEL, 480, expected lines per frame, used for geometry check.

Ports:
sys_clk  input  1  camera pixel clock (PCLK); all logic rising-edge.
sys_rst_n  input  1  asynchronous active-low reset.
cfg_done  input  1  sensor register configuration complete; level.
cam_vsync  input  1  camera frame sync, active high.
cam_href  input  1  camera line valid, active high.
cam_data  input  8  camera byte bus; high byte first, then low byte.
pre_wr_en  output  1  one-cycle pulse per assembled pixel.
ov5640_data  output  16  assembled RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
pre_href  output  1  line valid aligned to pre_wr_en timing, gated by frame_valid.
pre_vsync  output  1  frame sync aligned to pre_wr_en timing, gated by frame_valid.
frame_valid  output  1  high once skip count is done; frames are being forwarded.
frame_err  output  1  result of the geometry check for the last completed frame.

Behaviour:
- Reset state: all outputs 0, all counters 0, byte phase 0.
- Input stage:
  - cam_vsync, cam_href and cam_data are registered once (stage d1); vsync d1 is registered again (d2).
  - vs_rise = vsync_d1 & ~vsync_d2.
  - href_d1 is likewise registered again for hs_rise and hs_fall.
- Frame skip:
  - 4-bit-or-wider frame_cnt increments on vs_rise while cfg_done=1 and frame_cnt<FRAME_SKIP.
  - frame_valid sets on the first vs_rise with frame_cnt==FRAME_SKIP, so forwarding always starts on a frame boundary.
  - cfg_done=0 synchronously clears frame_cnt and frame_valid on the next edge. Any in-progress frame output stops immediately.
- Byte assembly:
  - Phase flag toggles each cycle href_d1=1 and is forced to 0 when href_d1=0.
  - Phase 0 latches the high byte. Phase 1 loads ov5640_data <= {high byte, cam_data_d1} and pulses pre_wr_en, gated by frame_valid.
  - Latency: if byte1 is on the pins at edge n+1, ov5640_data and pre_wr_en are valid after edge n+2.
  - ov5640_data holds its value between pulses. It updates even when frame_valid=0, but pre_wr_en stays 0.
- Odd byte count: if href falls while the phase is 1 (half pixel pending), the byte is discarded, no pre_wr_en is produced, and the line-error flag is set.
- Sync outputs:
  - pre_href = href_d1 & frame_valid, registered. It rises one cycle before the line's first pre_wr_en and falls one cycle after the last.
  - pre_vsync = vsync_d1 & frame_valid, registered, with the same 2-cycle pin-to-output latency.
- Geometry check:
  - 12-bit pix_cnt, saturating at 4095, clears on hs_rise and counts pre_wr_en.
  - On hs_fall, a line error is recorded if pix_cnt != H_PIXEL or a half pixel is pending.
  - 12-bit line_cnt clears on vs_rise and counts hs_fall.
  - On vs_rise, frame_err <= (line_cnt != V_PIXEL) | any line error. The accumulated flag then clears.
  - frame_err updates only if frame_valid was already 1 before that vs_rise, i.e. the frame was forwarded in full. Otherwise it holds.
- Simultaneous events: vs_rise while href_d1=1 is treated as hs_fall followed by frame end. The line is counted, and the line is checked before the frame check uses it.
- Reset mid-frame: everything returns to reset state, and the skip sequence restarts after cfg_done and FRAME_SKIP more vsync rises.

Test Plan:
- Skip count: cfg_done=1, FRAME_SKIP=2, send 4 frames of 4x3 (H_PIXEL=4, V_PIXEL=3) → pre_wr_en is 0 during frames 1–2; frame_valid rises at vs_rise of frame 3; 12 pulses each in frames 3 and 4.
- Assembly: bytes 0xF8,0x1F then 0x07,0xE0 → ov5640_data=0xF81F then 0x07E0; each pulse lands 2 cycles after its low byte is on the pins; pre_href is high 1 cycle before the first pulse.
- Odd byte: line of 9 bytes with H_PIXEL=4 → 4 pulses, last byte dropped, frame_err=1 at next vs_rise; next clean frame → frame_err=0.
- Wrong line count: frame with 2 lines of 4 pixels, V_PIXEL=3 → frame_err=1; pixel data is still forwarded.
- cfg_done drop: deassert cfg_done mid-line → frame_valid=0, pre_wr_en/pre_href/pre_vsync=0 from the next edge; reassert → skip restarts and frame_valid returns after FRAME_SKIP vsync rises.
- Async reset: assert sys_rst_n=0 mid-pixel between edges → all outputs 0 immediately without a clock edge; after release, frame_cnt restarts from 0.
